// File: rtl/word_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | word_serializer                                                          |
// | Parallel-to-serial converter: one WIDTH-bit word out as WIDTH beats on a |
// | valid/ready serial port, flagging the final bit of each word.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module word_serializer #(
  parameter int WIDTH     = 32,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  localparam int                 c_CNT_W = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_sr;
  logic [c_CNT_W-1:0] r_count;

  logic             w_head;
  logic [WIDTH-1:0] w_shifted;
  logic             w_shift;
  logic             w_last;
  logic             w_beat;

  // Output end of the shift register and its one-step advance (zero fill).
  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign w_head    = r_sr[0];
      assign w_shifted = {1'b0, r_sr[WIDTH-1:1]};
    end else begin : g_msb_first
      assign w_head    = r_sr[WIDTH-1];
      assign w_shifted = {r_sr[WIDTH-2:0], 1'b0};
    end
  endgenerate

  assign w_shift = (r_state == S_SHIFT);
  assign w_last  = (r_count == '0);
  assign w_beat  = w_shift & out_ready;

  assign out_valid = w_shift;
  assign busy      = w_shift;
  assign out_bit   = w_shift & w_head;
  assign out_last  = w_shift & w_last;
  // Combinational from out_ready so a new word can be taken on the last beat.
  assign in_ready  = (r_state == S_IDLE) | (w_beat & w_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sr    <= in_data;
            r_count <= c_LAST;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_beat) begin
            if (!w_last) begin
              r_sr    <= w_shifted;
              r_count <= r_count - c_ONE;
            end else if (in_valid) begin
              r_sr    <= in_data;
              r_count <= c_LAST;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_word_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_word_serializer                                                       |
// | Directed bench: 32-bit LSB-first and 8-bit MSB-first instances.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_word_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset_n, a_in_valid, a_in_ready, a_out_bit, a_out_valid;
  logic        a_out_ready, a_out_last, a_busy;
  logic [31:0] a_in_data;
  logic        b_reset_n, b_in_valid, b_in_ready, b_out_bit, b_out_valid;
  logic        b_out_ready, b_out_last, b_busy;
  logic [7:0]  b_in_data;

  int n_cmp  = 0;
  int n_fail = 0;

  word_serializer #(.WIDTH(32), .LSB_FIRST(1'b1)) u_dut_a (
    .clk(clk), .reset_n(a_reset_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out_bit(a_out_bit), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_last(a_out_last), .busy(a_busy)
  );

  word_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_dut_b (
    .clk(clk), .reset_n(b_reset_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_bit(b_out_bit), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_last(b_out_last), .busy(b_busy)
  );

  // Status vectors are {out_valid, out_last, busy, in_ready, out_bit}.
  task automatic test_reset();
    n_cmp++;
    if ({a_out_valid, a_out_last, a_busy, a_in_ready, a_out_bit} !== 5'b00010) begin
      n_fail++;
      $display("FAIL reset_poweron: got %b want 00010",
               {a_out_valid, a_out_last, a_busy, a_in_ready, a_out_bit});
    end
    @(posedge clk); #1 a_reset_n = 1'b1;
    @(posedge clk); #1 a_in_data = 32'hFFFF_FFFF; a_in_valid = 1'b1; a_out_ready = 1'b1;
    @(posedge clk); #1 a_in_valid = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({a_out_valid, a_out_last, a_busy, a_in_ready, a_out_bit} !== 5'b10101) begin
      n_fail++;
      $display("FAIL reset_midrun_pre: got %b want 10101",
               {a_out_valid, a_out_last, a_busy, a_in_ready, a_out_bit});
    end
    #2 a_reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({a_out_valid, a_out_last, a_busy, a_in_ready, a_out_bit} !== 5'b00010) begin
      n_fail++;
      $display("FAIL reset_async: got %b want 00010",
               {a_out_valid, a_out_last, a_busy, a_in_ready, a_out_bit});
    end
    @(posedge clk); #1 a_reset_n = 1'b1;
  endtask

  task automatic test_single();
    @(posedge clk); #1 a_in_data = 32'h0000_0001; a_in_valid = 1'b1; a_out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (a_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_idle_ready: got %b want 1", a_in_ready);
    end
    @(posedge clk); #1 a_in_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({a_out_valid, a_out_bit, a_out_last} !== {1'b1, i == 0, i == 31}) begin
        n_fail++;
        $display("FAIL single_beat%0d: got v/b/l %b want %b", i,
                 {a_out_valid, a_out_bit, a_out_last}, {1'b1, i == 0, i == 31});
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({a_out_valid, a_out_last, a_busy, a_in_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_idle_after: got %b want 0001",
               {a_out_valid, a_out_last, a_busy, a_in_ready});
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] stream;
    stream = {32'hFFFF_0000, 32'hA5A5_A5A5};
    @(posedge clk); #1 a_in_data = 32'hA5A5_A5A5; a_in_valid = 1'b1; a_out_ready = 1'b1;
    @(posedge clk); #1 a_in_data = 32'hFFFF_0000;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({a_out_valid, a_out_bit, a_out_last, a_in_ready} !==
          {1'b1, stream[i], (i == 31) || (i == 63), (i == 31) || (i == 63)}) begin
        n_fail++;
        $display("FAIL b2b_beat%0d: got v/b/l/r %b want %b", i,
                 {a_out_valid, a_out_bit, a_out_last, a_in_ready},
                 {1'b1, stream[i], (i == 31) || (i == 63), (i == 31) || (i == 63)});
      end
      if (i == 31) begin
        @(posedge clk); #1 a_in_valid = 1'b0;
      end
    end
    @(negedge clk);
    n_cmp++;
    if (a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle_after: got %b want 0", a_out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w, got;
    logic [15:0] pat;
    logic        pb, pl, pr;
    int          nb;
    w   = 32'hDEAD_BEEF;
    got = '0;
    pat = 16'b0110_1001_1101_0010;
    nb  = 0;
    pb  = 1'b0; pl = 1'b0; pr = 1'b1;
    @(posedge clk); #1 a_in_data = w; a_in_valid = 1'b1; a_out_ready = 1'b0;
    @(posedge clk); #1 a_in_valid = 1'b0; a_out_ready = pat[0];
    for (int c = 0; c < 200 && nb < 32; c++) begin
      @(negedge clk);
      if (!pr) begin
        n_cmp++;
        if ({a_out_bit, a_out_last} !== {pb, pl}) begin
          n_fail++;
          $display("FAIL bp_stall_hold c%0d: got b/l %b want %b", c,
                   {a_out_bit, a_out_last}, {pb, pl});
        end
      end
      n_cmp++;
      if ({a_out_valid, a_out_bit, a_out_last} !== {1'b1, w[nb], nb == 31}) begin
        n_fail++;
        $display("FAIL bp_beat%0d: got v/b/l %b want %b", nb,
                 {a_out_valid, a_out_bit, a_out_last}, {1'b1, w[nb], nb == 31});
      end
      pb = a_out_bit; pl = a_out_last; pr = a_out_ready;
      if (a_out_ready) begin
        got[nb] = a_out_bit;
        nb++;
      end
      @(posedge clk); #1 a_out_ready = pat[(c + 1) % 16];
    end
    a_out_ready = 1'b1;
    n_cmp++;
    if (nb != 32 || got !== w) begin
      n_fail++;
      $display("FAIL bp_word: got %h (%0d beats) want %h (32 beats)", got, nb, w);
    end
    @(negedge clk);
    n_cmp++;
    if (a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_idle_after: got %b want 0", a_out_valid);
    end
  endtask

  task automatic test_busy_refusal();
    logic [63:0] stream;
    stream = {32'h1234_5678, 32'hCAFE_F00D};
    @(posedge clk); #1 a_in_data = 32'hCAFE_F00D; a_in_valid = 1'b1; a_out_ready = 1'b1;
    @(posedge clk); #1 a_in_valid = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({a_out_valid, a_out_bit, a_out_last} !== {1'b1, stream[i], (i == 31) || (i == 63)}) begin
        n_fail++;
        $display("FAIL busy_beat%0d: got v/b/l %b want %b", i,
                 {a_out_valid, a_out_bit, a_out_last}, {1'b1, stream[i], (i == 31) || (i == 63)});
      end
      if (i >= 4 && i <= 31) begin
        n_cmp++;
        if (a_in_ready !== (i == 31)) begin
          n_fail++;
          $display("FAIL busy_in_ready beat%0d: got %b want %b", i, a_in_ready, i == 31);
        end
      end
      if (i == 3) begin
        @(posedge clk); #1 a_in_data = 32'h1234_5678; a_in_valid = 1'b1;
      end else if (i == 31) begin
        @(posedge clk); #1 a_in_valid = 1'b0;
      end
    end
    @(negedge clk);
    n_cmp++;
    if (a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_idle_after: got %b want 0", a_out_valid);
    end
  endtask

  task automatic test_msb_first();
    logic [7:0] exp_s;
    exp_s = 8'b1000_0011;
    @(posedge clk); #1 b_in_data = 8'b1000_0011; b_in_valid = 1'b1; b_out_ready = 1'b1;
    @(posedge clk); #1 b_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({b_out_valid, b_out_bit, b_out_last} !== {1'b1, exp_s[7 - i], i == 7}) begin
        n_fail++;
        $display("FAIL msb_beat%0d: got v/b/l %b want %b", i,
                 {b_out_valid, b_out_bit, b_out_last}, {1'b1, exp_s[7 - i], i == 7});
      end
    end
    @(posedge clk); #1 b_in_data = 8'h5A; b_in_valid = 1'b1;
    @(posedge clk); #1 b_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 b_reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({b_out_valid, b_out_last, b_busy, b_in_ready, b_out_bit} !== 5'b00010) begin
      n_fail++;
      $display("FAIL msb_reset_async: got %b want 00010",
               {b_out_valid, b_out_last, b_busy, b_in_ready, b_out_bit});
    end
    @(posedge clk); #1 b_reset_n = 1'b1; b_in_data = 8'hFF; b_in_valid = 1'b1;
    @(posedge clk); #1 b_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({b_out_valid, b_out_bit, b_out_last} !== {1'b1, 1'b1, i == 7}) begin
        n_fail++;
        $display("FAIL msb_ff_beat%0d: got v/b/l %b want %b", i,
                 {b_out_valid, b_out_bit, b_out_last}, {1'b1, 1'b1, i == 7});
      end
    end
    @(negedge clk);
    n_cmp++;
    if (b_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL msb_idle_after: got %b want 0", b_out_valid);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within 100000 ns");
    $fatal(1, "timeout");
  end

  initial begin
    a_reset_n = 1'b0; a_in_data = '0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    b_reset_n = 1'b0; b_in_data = '0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    #12;
    test_reset();
    b_reset_n = 1'b1;
    test_single();
    test_back_to_back();
    test_backpressure();
    test_busy_refusal();
    test_msb_first();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
